// File: rtl/apb_config_pkg.sv
// Shared types for the APB configuration register bank: FSM states, error codes
// and the latched request record.
package apb_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_DECODE = 2'd1;
  localparam logic [1:0] ERR_ALIGN  = 2'd2;
  localparam logic [1:0] ERR_RO     = 2'd3;

  localparam int IDX_W = 6;  // covers the 64-register ceiling
  localparam int CNT_W = 3;  // covers up to 7 wait states

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             write;
    logic [31:0]      wdata;
    logic [3:0]       strb;
    logic [1:0]       err;
  } req_t;

endpackage

// File: rtl/apb_config_reg.sv
// One configuration register: RW byte-strobed, write-1-to-clear with hardware
// set, or read-only mirror of a status input.
module apb_config_reg
  import apb_config_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit IS_RO  = 1'b0,
  parameter bit IS_W1C = 1'b0
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W/8-1:0] strb_i,
  input  logic [DATA_W-1:0] hw_status_i,
  input  logic [DATA_W-1:0] hw_set_i,
  output logic [DATA_W-1:0] q_o,
  output logic [DATA_W-1:0] rd_o,
  output logic              valid_o,
  output logic              pulse_o
);

  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] bmask, clr;
  logic              valid_q, pulse_q;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < DATA_W/8; k++) bmask[8*k +: 8] = {8{strb_i[k]}};
  end

  assign clr = wr_en_i ? (wdata_i & bmask) : '0;

  // Hardware set is applied after the clear so a coincident set wins.
  always_comb begin
    q_d = q_q;
    if (IS_RO)        q_d = q_q;
    else if (IS_W1C)  q_d = (q_q & ~clr) | hw_set_i;
    else if (wr_en_i) q_d = (q_q & ~bmask) | (wdata_i & bmask);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_q | wr_en_i;
      pulse_q <= wr_en_i & (|strb_i);
    end
  end

  assign q_o     = q_q;
  assign rd_o    = IS_RO ? hw_status_i : q_q;
  assign valid_o = valid_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/apb_config_bank.sv
// APB4 slave exposing NUM_REGS configuration registers with per-register
// RW / W1C / RO behaviour and optional access wait states.
module apb_config_bank
  import apb_config_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   ADDR_W      = 32,
  parameter int                   NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter int                   WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]  W1C_MASK    = '0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] cfg_o,
  output logic [NUM_REGS-1:0]        cfg_valid_o,
  output logic [NUM_REGS-1:0]        cfg_wr_pulse_o,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set_i
);

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  req_t                             req_q, req_d;
  logic [DATA_W-1:0]                prdata_q;

  logic [ADDR_W-1:0]                off, widx;
  logic                             in_range, dec_ro;
  logic [IDX_W-1:0]                 dec_idx;
  logic [1:0]                       dec_err;

  logic                             resp, ok, wr_go;
  logic [NUM_REGS-1:0]              wr_en;
  logic [NUM_REGS-1:0][DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]                rd_sel, rd_out;

  // Address decode on the live bus; the result is latched at access start.
  assign off      = paddr - BASE_ADDR;
  assign widx     = off >> 2;
  assign in_range = (paddr >= BASE_ADDR) && (widx < ADDR_W'(NUM_REGS));
  assign dec_idx  = widx[IDX_W-1:0];

  always_comb begin
    dec_ro = 1'b0;
    for (int n = 0; n < NUM_REGS; n++)
      if (dec_idx == IDX_W'(n)) dec_ro = RO_MASK[n];
  end

  always_comb begin
    dec_err = ERR_NONE;
    if (!in_range)              dec_err = ERR_DECODE;
    else if (paddr[1:0] != 2'b0) dec_err = ERR_ALIGN;
    else if (pwrite && dec_ro)  dec_err = ERR_RO;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && penable) begin
          req_d.idx   = dec_idx;
          req_d.write = pwrite;
          req_d.wdata = pwdata;
          req_d.strb  = pstrb;
          req_d.err   = dec_err;
          cnt_d       = '0;
          state_d     = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!psel)                                 state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(WAIT_STATES - 1)) state_d = ST_RESP;
        else                                       cnt_d   = cnt_q + 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      if (resp) prdata_q <= rd_out;
    end
  end

  // A master that abandons the access in RESP gets neither response nor update.
  assign resp  = (state_q == ST_RESP) && psel;
  assign ok    = resp && (req_q.err == ERR_NONE);
  assign wr_go = ok && req_q.write;

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    assign wr_en[n] = wr_go && (req_q.idx == IDX_W'(n));

    apb_config_reg #(
      .DATA_W (DATA_W),
      .IS_RO  (RO_MASK[n]),
      .IS_W1C (W1C_MASK[n])
    ) u_reg (
      .pclk        (pclk),
      .presetn     (presetn),
      .wr_en_i     (wr_en[n]),
      .wdata_i     (req_q.wdata),
      .strb_i      (req_q.strb),
      .hw_status_i (hw_status_i[n*DATA_W +: DATA_W]),
      .hw_set_i    (hw_set_i[n*DATA_W +: DATA_W]),
      .q_o         (cfg_o[n*DATA_W +: DATA_W]),
      .rd_o        (rd_val[n]),
      .valid_o     (cfg_valid_o[n]),
      .pulse_o     (cfg_wr_pulse_o[n])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < NUM_REGS; n++)
      if (req_q.idx == IDX_W'(n)) rd_sel = rd_val[n];
  end

  assign rd_out  = (ok && !req_q.write) ? rd_sel : '0;
  assign prdata  = resp ? rd_out : prdata_q;
  assign pready  = resp;
  assign pslverr = resp && (req_q.err != ERR_NONE);

endmodule

// File: tb/tb_apb_config_bank.sv
// Bench for apb_config_bank: directed table, W1C and reset sequences, and
// randomized traffic against an array-based register model.
module tb_apb_config_bank;

  localparam int          N       = 16;
  localparam logic [31:0] B0      = 32'h100;
  localparam int          RO_IDX  = 5;
  localparam int          W1C_IDX = 1;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              presetn_s [2];
  logic [31:0]       paddr_s   [2];
  logic              psel_s    [2];
  logic              penable_s [2];
  logic              pwrite_s  [2];
  logic [31:0]       pwdata_s  [2];
  logic [3:0]        pstrb_s   [2];
  logic [31:0]       prdata_s  [2];
  logic              pready_s  [2];
  logic              pslverr_s [2];
  logic [N*32-1:0]   cfg_s     [2];
  logic [N-1:0]      valid_s   [2];
  logic [N-1:0]      pulse_s   [2];
  logic [N*32-1:0]   hwstat_v, hwset_v0, hwset_v1;

  int checks = 0, errors = 0;
  logic [31:0] mdl [N];
  logic [N-1:0] mvalid;

  apb_config_bank #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(N), .BASE_ADDR(B0), .WAIT_STATES(0),
    .RO_MASK(16'h0020), .W1C_MASK(16'h0002)
  ) u_dut0 (
    .pclk(pclk), .presetn(presetn_s[0]), .paddr(paddr_s[0]), .psel(psel_s[0]),
    .penable(penable_s[0]), .pwrite(pwrite_s[0]), .pwdata(pwdata_s[0]), .pstrb(pstrb_s[0]),
    .prdata(prdata_s[0]), .pready(pready_s[0]), .pslverr(pslverr_s[0]), .cfg_o(cfg_s[0]),
    .cfg_valid_o(valid_s[0]), .cfg_wr_pulse_o(pulse_s[0]),
    .hw_status_i(hwstat_v), .hw_set_i(hwset_v0)
  );

  apb_config_bank #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(N), .WAIT_STATES(3)
  ) u_dut1 (
    .pclk(pclk), .presetn(presetn_s[1]), .paddr(paddr_s[1]), .psel(psel_s[1]),
    .penable(penable_s[1]), .pwrite(pwrite_s[1]), .pwdata(pwdata_s[1]), .pstrb(pstrb_s[1]),
    .prdata(prdata_s[1]), .pready(pready_s[1]), .pslverr(pslverr_s[1]), .cfg_o(cfg_s[1]),
    .cfg_valid_o(valid_s[1]), .cfg_wr_pulse_o(pulse_s[1]),
    .hw_status_i(hwstat_v), .hw_set_i(hwset_v1)
  );

  task automatic chk(input string nm, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*32-1:0] pack_mdl();
    logic [N*32-1:0] r;
    for (int n = 0; n < N; n++) r[n*32 +: 32] = mdl[n];
    return r;
  endfunction

  function automatic bit exp_err(input bit wr, input logic [31:0] a);
    logic [31:0] idx;
    if (a < B0 || a[1:0] != 2'b0) return 1'b1;
    idx = (a - B0) >> 2;
    if (idx >= N) return 1'b1;
    return wr && (idx == RO_IDX);
  endfunction

  // One APB transfer; returns just after the completing edge with psel dropped.
  task automatic apb(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output bit er, output int lat);
    @(negedge pclk);
    psel_s[d] = 1'b1; penable_s[d] = 1'b0; pwrite_s[d] = wr;
    paddr_s[d] = a; pwdata_s[d] = wd; pstrb_s[d] = st;
    @(negedge pclk);
    penable_s[d] = 1'b1;
    lat = 0;
    do begin
      @(posedge pclk); #1; lat++;
    end while (!pready_s[d] && lat < 20);
    chk("pready_seen", pready_s[d], 1);
    rd = prdata_s[d];
    er = pslverr_s[d];
    @(posedge pclk); #1;
    psel_s[d] = 1'b0; penable_s[d] = 1'b0;
    chk("pready_one_cycle", pready_s[d], 0);
  endtask

  // Transfer on the zero-wait bank with full model tracking and output checks.
  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output bit er);
    int lat, idx;
    bit e;
    logic [31:0] exp_rd, bm;
    logic [N-1:0] exp_p;
    apb(0, wr, a, wd, st, rd, er, lat);
    e = exp_err(wr, a);
    idx = int'((a - B0) >> 2);
    exp_rd = '0;
    if (!e && !wr) exp_rd = (idx == RO_IDX) ? hwstat_v[idx*32 +: 32] : mdl[idx];
    chk("lat", 32'(lat), 1);
    chk("pslverr", er, e);
    chk("prdata", rd, exp_rd);
    exp_p = '0;
    if (!e && wr) begin
      for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{st[k]}};
      if (idx == W1C_IDX) mdl[idx] = (mdl[idx] & ~(wd & bm)) | hwset_v0[idx*32 +: 32];
      else for (int k = 0; k < 4; k++) if (st[k]) mdl[idx][8*k +: 8] = wd[8*k +: 8];
      mvalid[idx] = 1'b1;
      exp_p[idx] = (st != 4'h0);
    end
    chk("cfg", cfg_s[0], pack_mdl());
    chk("valid", valid_s[0], mvalid);
    chk("pulse", pulse_s[0], exp_p);
    @(posedge pclk); #1;
    chk("pulse_end", pulse_s[0], 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t tbl [12];
    logic [31:0] rd, a;
    bit er;
    int lat;

    for (int d = 0; d < 2; d++) begin
      presetn_s[d] = 1'b0; paddr_s[d] = '0; psel_s[d] = 1'b0; penable_s[d] = 1'b0;
      pwrite_s[d] = 1'b0; pwdata_s[d] = '0; pstrb_s[d] = '0;
    end
    for (int n = 0; n < N; n++) begin
      hwstat_v[n*32 +: 32] = 32'hA500_0000 | 32'(n);
      mdl[n] = '0;
    end
    hwset_v0 = '0; hwset_v1 = '0; mvalid = '0;

    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_pready", pready_s[d], 0);
      chk("rst_pslverr", pslverr_s[d], 0);
      chk("rst_prdata", prdata_s[d], 0);
      chk("rst_cfg", cfg_s[d], 0);
      chk("rst_valid", valid_s[d], 0);
      chk("rst_pulse", pulse_s[d], 0);
    end
    @(negedge pclk);
    presetn_s[0] = 1'b1; presetn_s[1] = 1'b1;

    tbl[0]  = '{1'b1, 32'h108, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h108, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h108, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 32'h108, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    tbl[4]  = '{1'b0, 32'h140, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[5]  = '{1'b0, 32'h102, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[6]  = '{1'b1, 32'h114, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    tbl[7]  = '{1'b0, 32'h114, 32'h0,         4'h0, 32'hA500_0005, 1'b0};
    tbl[8]  = '{1'b1, 32'h10C, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 32'h10C, 32'h0,         4'h0, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h0FC, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[11] = '{1'b1, 32'h104, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
    for (int i = 0; i < 12; i++) begin
      do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
    end

    // W1C: hardware set held across a clearing write must survive it.
    @(negedge pclk);
    hwset_v0[W1C_IDX*32] = 1'b1;
    @(posedge pclk); #1;
    mdl[W1C_IDX] = mdl[W1C_IDX] | 32'h1;
    chk("w1c_hw_set", cfg_s[0][W1C_IDX*32 +: 32], mdl[W1C_IDX]);
    do_xfer(1'b1, B0 + 32'h4, 32'h1, 4'hF, rd, er);
    chk("w1c_set_wins", cfg_s[0][W1C_IDX*32], 1);
    hwset_v0 = '0;
    do_xfer(1'b1, B0 + 32'h4, 32'h1, 4'hF, rd, er);
    chk("w1c_cleared", cfg_s[0][W1C_IDX*32], 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(9))
        8:       a = B0 + 32'(4 * N) + 32'(4 * $urandom_range(3));
        9:       a = B0 + 32'($urandom_range(3)) + ($urandom_range(1) ? 32'(4 * $urandom_range(N - 1)) : -32'h4);
        default: a = B0 + 32'(4 * $urandom_range(N - 1));
      endcase
      do_xfer(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), rd, er);
    end

    // Three wait states: pready four cycles after penable.
    apb(1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chk("ws3_lat", 32'(lat), 4);
    chk("ws3_err", er, 0);
    chk("ws3_cfg", cfg_s[1][4*32 +: 32], 32'hCAFE_F00D);
    chk("ws3_pulse", pulse_s[1], 16'h0010);

    // Reset while the access sits in WAIT.
    @(negedge pclk);
    psel_s[1] = 1'b1; penable_s[1] = 1'b0; pwrite_s[1] = 1'b1;
    paddr_s[1] = 32'h10; pwdata_s[1] = 32'h1234_5678; pstrb_s[1] = 4'hF;
    @(negedge pclk);
    penable_s[1] = 1'b1;
    @(posedge pclk); @(posedge pclk); #1;
    chk("ws3_in_wait", pready_s[1], 0);
    @(negedge pclk);
    presetn_s[1] = 1'b0;
    #1;
    chk("midrst_cfg", cfg_s[1], 0);
    chk("midrst_valid", valid_s[1], 0);
    chk("midrst_pready", pready_s[1], 0);
    @(negedge pclk);
    psel_s[1] = 1'b0; penable_s[1] = 1'b0; presetn_s[1] = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    chk("postrst_cfg", cfg_s[1], 0);
    chk("postrst_pulse", pulse_s[1], 0);
    apb(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("postrst_rd", rd, 0);
    chk("postrst_err", er, 0);
    chk("postrst_lat", 32'(lat), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_config_bank.md
APB_CONFIG_BANK -- requirements
Module: apb_config_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, APB data width; only 32 is legal.
REQ-002 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; legal range 1..64.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0.
REQ-005 SHALL have parameter WAIT_STATES, default 0, extra access-phase cycles; legal range 0..7.
REQ-006 SHALL have parameter RO_MASK, default all-zero, NUM_REGS bits; bit n=1 makes register n read-only.
REQ-007 SHALL have parameter W1C_MASK, default all-zero, NUM_REGS bits; bit n=1 makes register n write-1-to-clear.
REQ-008 SHALL have port pclk, input, 1, clock.
REQ-009 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports paddr/psel/penable/pwrite, input, ADDR_W/1/1/1, APB4 request.
REQ-011 SHALL have port pwdata, input, DATA_W, write data.
REQ-012 SHALL have port pstrb, input, DATA_W/8, byte write strobes.
REQ-013 SHALL have ports prdata/pready/pslverr, output, DATA_W/1/1, APB response.
REQ-014 SHALL have port cfg_o, output, NUM_REGS*DATA_W, flattened register values, register n at bits [n*DATA_W +: DATA_W].
REQ-015 SHALL have port cfg_valid_o, output, NUM_REGS, sticky flag set by the first accepted write to register n.
REQ-016 SHALL have port cfg_wr_pulse_o, output, NUM_REGS, one-cycle pulse per accepted write to register n.
REQ-017 SHALL have port hw_status_i, input, NUM_REGS*DATA_W, read value of RO registers.
REQ-018 SHALL have port hw_set_i, input, NUM_REGS*DATA_W, per-bit set requests for W1C registers.

Function
REQ-019 SHALL decode index = (paddr-BASE_ADDR)>>2; an access is valid if paddr>=BASE_ADDR, paddr[1:0]==0 and index<NUM_REGS.
REQ-020 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-021 SHALL, in IDLE, on psel&penable, latch the request and go to WAIT when WAIT_STATES>0, else to RESP.
REQ-022 SHALL count WAIT_STATES cycles in WAIT, then go to RESP.
REQ-023 SHALL assert pready for exactly one cycle in RESP, then return to IDLE.
REQ-024 SHALL give a 1-wait-cycle response when WAIT_STATES=0, i.e. pready the cycle after penable is first seen.
REQ-025 SHALL perform the register update and prdata capture on the RESP cycle only.
REQ-026 SHALL update a plain RW register byte-wise: byte k takes pwdata byte k where pstrb[k]=1.
REQ-027 SHALL clear a W1C register bit where pwdata bit=1 and its byte strobe=1.
REQ-028 SHALL set a W1C register bit every cycle hw_set_i bit=1; a set SHALL win over a simultaneous clear.
REQ-029 SHALL not alter an RO register on write, and SHALL return hw_status_i slice n on read.
REQ-030 SHALL assert pslverr with pready for: invalid address, misalignment, or a write to an RO register; such accesses SHALL cause no state change.
REQ-031 SHALL drive prdata with the register value on a valid read and with 0 on error or write responses; prdata SHALL hold its value outside RESP.
REQ-032 SHALL set cfg_valid_o[n] and pulse cfg_wr_pulse_o[n] on the cycle after a successful write to register n.
REQ-033 SHALL not pulse cfg_wr_pulse_o on writes with pstrb=0; the write still completes without error.
REQ-034 SHALL return to IDLE without a response when psel drops mid-access.

Reset
REQ-035 SHALL, while presetn=0, force the FSM to IDLE and drive prdata=0, pready=0, pslverr=0, cfg_o=0, cfg_valid_o=0, cfg_wr_pulse_o=0.
REQ-036 SHALL abandon a pending transfer on reset mid-transfer, with no register update.

Structure
REQ-037 SHALL keep FSM state encodings and the error-code localparams in package apb_config_pkg.
REQ-038 SHALL place the per-register storage (RW/W1C/RO update logic) in sub-module apb_config_reg, instantiated NUM_REGS times by generate.

Verification
REQ-039 SHALL be covered by a test where, with WAIT_STATES=0, a write of 0xDEADBEEF to reg 2 with pstrb=0xF produces cfg_o reg2=0xDEADBEEF, a one-cycle cfg_wr_pulse_o[2], and cfg_valid_o[2]=1.
REQ-040 SHALL be covered by a test where a write of 0x11223344 with pstrb=0x5 over reg 2 holding 0xDEADBEEF yields 0xDE22BE44.
REQ-041 SHALL be covered by a test where, with WAIT_STATES=3, pready rises exactly 4 cycles after penable.
REQ-042 SHALL be covered by a test where, with W1C_MASK bit 1 set, hw_set_i=0x1 and a write of 0x1 in the same cycle leave reg1 bit0=1, and a later write of 0x1 clears it.
REQ-043 SHALL be covered by a test where a read of BASE_ADDR+4*NUM_REGS, a read of BASE_ADDR+2, and a write to an RO register each give pslverr=1 and prdata=0, with no register change.
REQ-044 SHALL be covered by a test where presetn is asserted during WAIT and the following access returns reset values.
